countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 17 +
 rtl/prescaler_tick.sv | 34 +++
 rtl/countdown_timer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding and a width helper.
package timer_pkg;

    // Timer FSM states; also exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bits needed to hold 0..modulus-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one.
// tick is combinational so the owner sees it in the same cycle the phase
// reaches PRESCALE-1; the phase wraps to 0 on that edge.
module prescaler_tick
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;
    logic          w_at_last;

    assign w_at_last = (r_phase == LAST);
    assign tick      = enable && w_at_last;

    // Phase counter: cleared by reset/clear, advances only while enabled.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_phase <= '0;
        end else if (enable) begin
            r_phase <= w_at_last ? '0 : r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with prescaler, pause/resume and auto-reload.
// Input priority on each edge: reset > load > start > pause.
// done is a registered one-cycle pulse produced on every terminal count.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [N-1:0] count,
    output logic         running,
    output logic         done,
    output state_e       dbg_state
);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [N-1:0] r_count;
    logic [N-1:0] w_count_nxt;
    logic [N-1:0] r_reload;
    logic [N-1:0] w_reload_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_hold;
    logic         w_pre_en;
    logic         w_pre_clear;
    logic         w_tick;

    // A pause request only takes effect when start is not also asserted.
    assign w_hold = pause && !start;

    // The prescaler runs only on RUN cycles that stay in RUN and keep their
    // count path; a pausing edge freezes the phase so resume picks it up.
    assign w_pre_en = (r_state == RUN) && !load && !w_hold;

    // Restart the phase on load and whenever a fresh countdown begins.
    assign w_pre_clear = load || (start && ((r_state == IDLE) || (r_state == DONE)));

    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_pre_clear),
        .enable (w_pre_en),
        .tick   (w_tick)
    );

    // Next-state and datapath decisions; everything defaults to hold.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_state_nxt  = IDLE;
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (r_count != '0) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_hold) begin
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        if (r_count > N'(1)) begin
                            w_count_nxt = r_count - 1'b1;
                        end else if (auto_reload && (r_reload != '0)) begin
                            // Reload straight from 1 so count never shows 0.
                            w_count_nxt = r_reload;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_count_nxt = '0;
                    if (start) begin
                        if (r_reload != '0) begin
                            w_count_nxt = r_reload;
                            w_state_nxt = RUN;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, count, reload and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign count     = r_count;
    assign running   = (r_state == RUN);
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
